// File: rtl/alarm_pkg.sv
// Shared definitions for the car alarm: controller state encodings,
// time-parameter register selectors and the power-up time values (seconds).
package alarm_pkg;

  typedef enum logic [2:0] {
    S_ARMED      = 3'd0,
    S_TRIGGERED  = 3'd1,
    S_SOUND      = 3'd2,
    S_DISARMED   = 3'd3,
    S_WAIT_OPEN  = 3'd4,
    S_WAIT_CLOSE = 3'd5,
    S_ARMING     = 3'd6
  } state_e;

  // param_sel codes for the reprogram port
  localparam logic [1:0] SEL_T_ARM       = 2'd0;
  localparam logic [1:0] SEL_T_DRIVER    = 2'd1;
  localparam logic [1:0] SEL_T_PASSENGER = 2'd2;
  localparam logic [1:0] SEL_T_ALARM     = 2'd3;

  // Time values loaded by reset, in seconds
  localparam int DEF_T_ARM       = 6;
  localparam int DEF_T_DRIVER    = 8;
  localparam int DEF_T_PASSENGER = 15;
  localparam int DEF_T_ALARM     = 10;

endpackage

// File: rtl/alarm_sec_timer.sv
// Seconds countdown timer with its own quarter-second-based prescaler.
//   clk, reset   : clock, synchronous active-high reset
//   start        : load load_value into countdown and restart the prescaler
//   stop         : abandon the count, countdown returns to 0
//   load_value   : seconds to count (0 expires the cycle after the load)
//   countdown    : seconds remaining (registered)
//   expired      : one-cycle pulse, high in the cycle the count reaches 0
// start wins over stop if both are asserted.
module alarm_sec_timer #(
  parameter int TV_W     = 4,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic [TV_W-1:0] load_value,
  output logic [TV_W-1:0] countdown,
  output logic            expired
);

  localparam int SEC_CYC = 4 * TICK_DIV;
  localparam int PW      = $clog2(SEC_CYC);

  logic [PW-1:0] pre_cnt;
  logic          running;
  logic          sec_end;

  assign sec_end = (pre_cnt == PW'(SEC_CYC - 1));

  // Combinational so the controller can act in the same cycle the final
  // second ends; a zero load expires on its first running cycle.
  assign expired = running &&
                   ((countdown == '0) || ((countdown == TV_W'(1)) && sec_end));

  // NOTE: non-blocking assignments make every flop here sample pre-edge values,
  // so expired and the decrement agree on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt   <= '0;
      countdown <= '0;
      running   <= 1'b0;
    end else if (start) begin
      pre_cnt   <= '0;
      countdown <= load_value;
      running   <= 1'b1;
    end else if (stop || expired) begin
      pre_cnt   <= '0;
      countdown <= '0;
      running   <= 1'b0;
    end else if (running) begin
      if (sec_end) begin
        pre_cnt   <= '0;
        countdown <= countdown - TV_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_fsm_nch.sv
// Car alarm controller with N door channels.
//   clk, reset      : clock, synchronous active-high reset
//   ignition        : key on; disarms from any active state
//   door[N_DOORS]   : 1 = open (debounced); DRIVER_MASK bits use the driver delay
//   brake, hidden_sw: with ignition, enable the fuel pump
//   reprogram       : write pulse; param_value -> time register param_sel
//   siren           : 2 Hz square wave while sounding
//   status          : 0.5 Hz blink when armed, steady on when triggered/sounding
//   fuel_pump       : pump enable gated by ignition
//   state           : controller state (alarm_pkg::state_e encoding)
//   countdown       : seconds left on the running timer
//   alarm_count     : number of alarm soundings, saturating at 255
module alarm_fsm_nch
  import alarm_pkg::*;
#(
  parameter int                 N_DOORS     = 4,
  parameter logic [N_DOORS-1:0] DRIVER_MASK = N_DOORS'(4'b0001),
  parameter int                 TV_W        = 4,
  parameter int                 TICK_DIV    = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] door,
  input  logic               brake,
  input  logic               hidden_sw,
  input  logic               reprogram,
  input  logic [1:0]         param_sel,
  input  logic [TV_W-1:0]    param_value,
  output logic               siren,
  output logic               status,
  output logic               fuel_pump,
  output logic [2:0]         state,
  output logic [TV_W-1:0]    countdown,
  output logic [7:0]         alarm_count
);

  localparam int QW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e          state_q, state_nx;
  logic [TV_W-1:0] t_param [4];
  logic [QW-1:0]   q_cnt;
  logic [1:0]      sec_cnt;
  logic            q_tick, sec_tick;
  logic            pump_en, pump_en_nx;
  logic            door_any, door_driver;
  logic            tmr_start, tmr_stop, tmr_expired;
  logic [TV_W-1:0] tmr_value;

  // Free-running prescaler for the siren and status blink; unlike the
  // timer's prescaler it is never restarted by the controller.
  assign q_tick   = (q_cnt == QW'(TICK_DIV - 1));
  assign sec_tick = q_tick && (sec_cnt == 2'd3);

  assign door_any    = |door;
  assign door_driver = |(door & DRIVER_MASK);

  // Enable latches on ignition+brake+hidden_sw and drops with ignition.
  assign pump_en_nx = (ignition & brake & hidden_sw) | (pump_en & ignition);

  alarm_sec_timer #(
    .TV_W     (TV_W),
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (tmr_start),
    .stop       (tmr_stop),
    .load_value (tmr_value),
    .countdown  (countdown),
    .expired    (tmr_expired)
  );

  // Transition decision and timer command; reprogram beats ignition,
  // which beats the per-state rules.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nx  = state_q;
    tmr_start = 1'b0;
    tmr_stop  = 1'b0;
    tmr_value = '0;
    if (reprogram) begin
      state_nx = S_ARMED;
      tmr_stop = 1'b1;
    end else if (ignition && (state_q != S_DISARMED)) begin
      state_nx = S_DISARMED;
      tmr_stop = 1'b1;
    end else begin
      case (state_q)
        S_ARMED: if (door_any) begin
          state_nx  = S_TRIGGERED;
          tmr_start = 1'b1;
          tmr_value = door_driver ? t_param[SEL_T_DRIVER] : t_param[SEL_T_PASSENGER];
        end
        S_TRIGGERED: if (tmr_expired) begin
          state_nx  = S_SOUND;
          tmr_start = 1'b1;
          tmr_value = t_param[SEL_T_ALARM];
        end
        // An open door keeps the alarm going by reloading every cycle.
        S_SOUND: if (door_any) begin
          tmr_start = 1'b1;
          tmr_value = t_param[SEL_T_ALARM];
        end else if (tmr_expired) begin
          state_nx = S_ARMED;
        end
        S_DISARMED:  if (!ignition)   state_nx = S_WAIT_OPEN;
        S_WAIT_OPEN: if (door_driver) state_nx = S_WAIT_CLOSE;
        S_WAIT_CLOSE: if (!door_any) begin
          state_nx  = S_ARMING;
          tmr_start = 1'b1;
          tmr_value = t_param[SEL_T_ARM];
        end
        S_ARMING: if (door_any) begin
          state_nx = S_WAIT_CLOSE;
          tmr_stop = 1'b1;
        end else if (tmr_expired) begin
          state_nx = S_ARMED;
        end
        default: state_nx = S_ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ARMED;
      siren       <= 1'b0;
      status      <= 1'b0;
      pump_en     <= 1'b0;
      fuel_pump   <= 1'b0;
      alarm_count <= '0;
      q_cnt       <= '0;
      sec_cnt     <= '0;
      // NOTE: these four time registers are plain flops, not RAM, so they
      // take their defaults on reset like any other state.
      t_param[SEL_T_ARM]       <= TV_W'(DEF_T_ARM);
      t_param[SEL_T_DRIVER]    <= TV_W'(DEF_T_DRIVER);
      t_param[SEL_T_PASSENGER] <= TV_W'(DEF_T_PASSENGER);
      t_param[SEL_T_ALARM]     <= TV_W'(DEF_T_ALARM);
    end else begin
      q_cnt <= q_tick ? '0 : q_cnt + QW'(1);
      if (q_tick) sec_cnt <= sec_cnt + 2'd1;

      if (reprogram) t_param[param_sel] <= param_value;

      state_q <= state_nx;

      // Outputs follow the state being entered, so they line up with state.
      if (state_nx == S_SOUND)
        siren <= (state_q == S_SOUND) ? (siren ^ q_tick) : 1'b1;
      else
        siren <= 1'b0;

      // Blink phase restarts from 0 whenever ARMED is re-entered.
      if (state_nx == S_ARMED)
        status <= (state_q == S_ARMED) ? (status ^ sec_tick) : 1'b0;
      else
        status <= (state_nx == S_TRIGGERED) || (state_nx == S_SOUND);

      if ((state_nx == S_SOUND) && (state_q != S_SOUND) && (alarm_count != 8'hFF))
        alarm_count <= alarm_count + 8'd1;

      pump_en   <= pump_en_nx;
      fuel_pump <= pump_en_nx & ignition;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_fsm_nch.sv
// Directed bench for alarm_fsm_nch with TICK_DIV=2 (one second = 8 cycles).
// A cycle model tracks deadlines as absolute edge numbers and derives the
// ticks from the edge count since reset; a compare process checks every
// output against it on each falling edge, and the directed sequence adds
// literal expectations for latencies and values.
module tb_alarm_fsm_nch;

  localparam int TD  = 2;
  localparam int SEC = 4 * TD;
  localparam logic [3:0] MASK = 4'b0001;

  localparam int ARMED = 0, TRIGGERED = 1, SOUND = 2, DISARMED = 3;
  localparam int WAIT_OPEN = 4, WAIT_CLOSE = 5, ARMING = 6;

  logic       clk = 1'b0;
  logic       reset, ignition, brake, hidden_sw, reprogram;
  logic [3:0] door;
  logic [1:0] param_sel;
  logic [3:0] param_value;
  logic       siren, status, fuel_pump;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [7:0] alarm_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alarm_fsm_nch #(
    .N_DOORS     (4),
    .DRIVER_MASK (MASK),
    .TV_W        (4),
    .TICK_DIV    (TD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ignition    (ignition),
    .door        (door),
    .brake       (brake),
    .hidden_sw   (hidden_sw),
    .reprogram   (reprogram),
    .param_sel   (param_sel),
    .param_value (param_value),
    .siren       (siren),
    .status      (status),
    .fuel_pump   (fuel_pump),
    .state       (state),
    .countdown   (countdown),
    .alarm_count (alarm_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit model_valid = 1'b0;
  int edge_n = 0;
  int since_rst;
  int m_state, m_count, m_cd;
  bit m_siren, m_status, m_en, m_pump;
  int prm [4];
  bit t_run;
  int t_load, t_val;

  task automatic arm_timer(input int v);
    t_run  = 1'b1;
    t_load = edge_n;
    t_val  = v;
  endtask

  always @(posedge clk) begin : model
    int prev, nxt;
    bit q, s, exp_now, any_open, drv_open;
    edge_n++;
    if (reset === 1'b1) begin
      model_valid = 1'b1;
      since_rst = 0;
      m_state = ARMED; m_siren = 0; m_status = 0; m_en = 0; m_pump = 0; m_count = 0;
      t_run = 0;
      prm = '{6, 8, 15, 10};
    end else if (model_valid) begin
      since_rst++;
      q = (since_rst % TD) == 0;
      s = (since_rst % SEC) == 0;
      exp_now = t_run && (edge_n == t_load + ((t_val == 0) ? 1 : t_val * SEC));
      if (exp_now) t_run = 0;
      any_open = (door != 4'b0);
      drv_open = ((door & MASK) != 4'b0);
      prev = m_state;
      nxt = prev;
      if (reprogram) begin
        prm[param_sel] = int'(param_value);
        nxt = ARMED;
        t_run = 0;
      end else if (ignition && prev != DISARMED) begin
        nxt = DISARMED;
        t_run = 0;
      end else begin
        case (prev)
          ARMED:      if (any_open) begin nxt = TRIGGERED; arm_timer(drv_open ? prm[1] : prm[2]); end
          TRIGGERED:  if (exp_now) begin nxt = SOUND; arm_timer(prm[3]); end
          SOUND:      if (any_open) arm_timer(prm[3]); else if (exp_now) nxt = ARMED;
          DISARMED:   if (!ignition) nxt = WAIT_OPEN;
          WAIT_OPEN:  if (drv_open) nxt = WAIT_CLOSE;
          WAIT_CLOSE: if (!any_open) begin nxt = ARMING; arm_timer(prm[0]); end
          ARMING:     if (any_open) begin nxt = WAIT_CLOSE; t_run = 0; end
                      else if (exp_now) nxt = ARMED;
          default:    nxt = ARMED;
        endcase
      end
      m_siren  = (nxt == SOUND) ? ((prev == SOUND) ? (m_siren ^ q) : 1'b1) : 1'b0;
      m_status = (nxt == ARMED) ? ((prev == ARMED) ? (m_status ^ s) : 1'b0)
                                : (nxt == TRIGGERED || nxt == SOUND);
      if (nxt == SOUND && prev != SOUND && m_count < 255) m_count++;
      if (ignition && brake && hidden_sw) m_en = 1'b1;
      else if (!ignition) m_en = 1'b0;
      m_pump = m_en && ignition;
      m_state = nxt;
    end
    m_cd = t_run ? (t_val - (edge_n - t_load) / SEC) : 0;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("state",       state,       m_state);
      check("countdown",   countdown,   m_cd);
      check("siren",       siren,       m_siren);
      check("status",      status,      m_status);
      check("fuel_pump",   fuel_pump,   m_pump);
      check("alarm_count", alarm_count, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int target, input int limit);
    int n = 0;
    while (int'(state) != target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("reach_state", state, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1; ignition = 0; door = 0; brake = 0; hidden_sw = 0;
    reprogram = 0; param_sel = 0; param_value = 0;
    step(3);
    check("rst_state", state, ARMED);
    check("rst_countdown", countdown, 0);
    check("rst_siren", siren, 0);
    check("rst_status", status, 0);
    check("rst_pump", fuel_pump, 0);
    check("rst_count", alarm_count, 0);
    reset = 0;
    step(20);

    // reset abandons a running countdown without an expiry
    door = 4'b0010; step(1);
    check("pass_cd", countdown, 15);
    door = 0; step(30);
    reset = 1; step(1);
    check("midrst_state", state, ARMED);
    check("midrst_cd", countdown, 0);
    reset = 0; step(130);
    check("midrst_no_alarm", alarm_count, 0);

    // passenger door: SOUND 120 cycles after load, then 80 cycles of alarm
    door = 4'b0010; step(1); t0 = edge_n;
    check("trig_state", state, TRIGGERED);
    check("trig_cd", countdown, 15);
    step(8); door = 4'b0100; step(1); door = 0;
    wait_state(SOUND, 200);
    check("sound_latency", edge_n - t0, 120);
    check("sound_count", alarm_count, 1);
    check("sound_siren_on", siren, 1);
    t0 = edge_n;
    wait_state(ARMED, 100);
    check("alarm_length", edge_n - t0, 80);

    // driver door, ignition at cycle 30 disarms
    door = 4'b0001; step(1); t0 = edge_n;
    check("drv_cd", countdown, 8);
    door = 0; step(29);
    ignition = 1; step(1);
    check("ign_state", state, DISARMED);
    check("ign_siren", siren, 0);
    check("ign_count", alarm_count, 1);

    // exit and re-arm sequence
    ignition = 0; step(1);
    check("wait_open", state, WAIT_OPEN);
    door = 4'b0001; step(1);
    check("wait_close", state, WAIT_CLOSE);
    door = 0; step(1);
    check("arming", state, ARMING);
    check("arming_cd", countdown, 6);
    step(19); door = 4'b0010; step(1);
    check("reopen_state", state, WAIT_CLOSE);
    check("reopen_cd", countdown, 0);
    door = 0; step(1); t0 = edge_n;
    check("rearm_state", state, ARMING);
    wait_state(ARMED, 100);
    check("arm_latency", edge_n - t0, 48);

    // door held open during SOUND keeps reloading
    door = 4'b0010; step(1);
    wait_state(SOUND, 200);
    check("sound2_count", alarm_count, 2);
    step(50);
    check("held_cd", countdown, 10);
    door = 0; t0 = edge_n;
    wait_state(ARMED, 120);
    check("close_to_armed", edge_n - t0, 80);

    // reprogram T_ALARM=0 during TRIGGERED
    door = 4'b0100; step(1); door = 0; step(5);
    check("trig3_state", state, TRIGGERED);
    reprogram = 1; param_sel = 2'd3; param_value = 4'd0; step(1); reprogram = 0;
    check("reprog_state", state, ARMED);
    check("reprog_cd", countdown, 0);
    door = 4'b0001; step(1); door = 0; t0 = edge_n;
    check("trig4_cd", countdown, 8);
    wait_state(SOUND, 100);
    check("trig4_latency", edge_n - t0, 64);
    step(1);
    check("zero_alarm_state", state, ARMED);
    check("zero_alarm_count", alarm_count, 3);

    // reprogram outranks ignition
    ignition = 1; reprogram = 1; param_sel = 2'd3; param_value = 4'd10; step(1);
    reprogram = 0;
    check("prio_state", state, ARMED);
    step(1);
    check("prio_ign", state, DISARMED);

    // fuel pump
    brake = 1; step(1);
    check("pump_brake_only", fuel_pump, 0);
    hidden_sw = 1; step(1);
    check("pump_on", fuel_pump, 1);
    brake = 0; hidden_sw = 0; step(1);
    check("pump_hold", fuel_pump, 1);
    ignition = 0; step(1);
    check("pump_off", fuel_pump, 0);
    ignition = 1; step(1);
    check("pump_stays_off", fuel_pump, 0);
    ignition = 0; step(1);

    // fast alarms to saturate alarm_count
    reprogram = 1; param_sel = 2'd1; param_value = 4'd0; step(1);
    param_sel = 2'd3; param_value = 4'd0; step(1);
    reprogram = 0;
    for (int i = 0; i < 260; i++) begin
      door = 4'b0001; step(1);
      door = 0; step(3);
    end
    check("sat_count", alarm_count, 255);
    check("sat_state", state, ARMED);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
